// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, hands it to fetch over valid/ready, and steps it
// once per instruction (trap > branch > return > sequential). Define PC_RAS_EN for the return-address stack.
module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              PC_STEP   = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            next_pc_make,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_pc,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            stall,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic            misalign,
  output logic            ras_empty
);

  typedef enum logic {ST_ISSUE, ST_WAIT} state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t          state;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            br_misaligned;
  logic            ret_hit;
  logic            ret_fall;
  logic            accept;

  assign seq_pc        = pc + STEP;
  assign br_misaligned = branch && (PC_STEP == 4) && (branch_pc[1:0] != 2'b00);
  assign accept        = (state == ST_WAIT) && next_pc_make && !stall && !trap && !br_misaligned;

`ifdef PC_RAS_EN
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   ras_sp;
  logic [AW:0]     ras_cnt;
  logic [AW-1:0]   ras_top_idx;
  logic            ras_push;

  assign ras_top_idx = ras_sp - 1'b1;
  assign ras_top     = ras_mem[ras_top_idx];
  assign ras_empty   = (ras_cnt == '0);
  assign ret_hit     = ret && !ras_empty;
  assign ret_fall    = ret && ras_empty;
  assign ras_push    = branch && call;

  // Circular stack: when full, a push lands on the oldest slot and the count saturates.
  always_ff @(posedge clk) begin
    if (!rst_n || trap) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
    end else if (accept) begin
      if (ras_push && ret_hit) begin
        ras_mem[ras_top_idx] <= seq_pc;
      end else if (ras_push) begin
        ras_mem[ras_sp] <= seq_pc;
        ras_sp          <= ras_sp + 1'b1;
        if (ras_cnt != (AW+1)'(RAS_DEPTH))
          ras_cnt <= ras_cnt + 1'b1;
      end else if (ret_hit) begin
        ras_sp  <= ras_top_idx;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end
`else
  logic unused_ras_in;

  assign unused_ras_in = call ^ ret;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ret_hit       = 1'b0;
  assign ret_fall      = 1'b0;
`endif

  always_comb begin
    next_pc = seq_pc;
    if (branch)
      next_pc = branch_pc;
    else if (ret_hit)
      next_pc = ras_top;
    else if (ret_fall)
      next_pc = branch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= ST_ISSUE;
      fetch_valid <= 1'b1;
      misalign    <= 1'b0;
    end else if (trap) begin
      pc          <= trap_pc;
      state       <= ST_ISSUE;
      fetch_valid <= 1'b1;
      misalign    <= 1'b0;
    end else if (!stall) begin
      case (state)
        ST_ISSUE: begin
          if (fetch_ready) begin
            state       <= ST_WAIT;
            fetch_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A misaligned taken branch is rejected: PC stays put and the core must trap out.
          if (next_pc_make) begin
            if (br_misaligned) begin
              misalign <= 1'b1;
            end else begin
              pc          <= next_pc;
              state       <= ST_ISSUE;
              fetch_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // The pc must not move under a live fetch unless a trap redirects it.
  property p_pc_stable_while_valid;
    @(posedge clk) disable iff (!rst_n)
      (fetch_valid && !trap) |=> (rst_n == 1'b0) || ($past(trap)) || (pc == $past(pc));
  endproperty
  a_pc_stable_while_valid: assert property (p_pc_stable_while_valid);

endmodule
